// File: rtl/dic_time_tx_fsm_if.sv
// UART TX byte handshake between the time line encoder (master) and the transmitter (slave).
interface dic_time_tx_fsm_if;
    logic [7:0] tx_data;
    logic       tx_vld;
    logic       tx_rdy;

    modport master (
        output tx_data,
        output tx_vld,
        input  tx_rdy
    );

    modport slave (
        input  tx_data,
        input  tx_vld,
        output tx_rdy
    );
endinterface

// File: rtl/dic_time_tx_fsm.sv
// Encodes the BCD clock time as an ASCII line "MM:SS\r\n" for the UART transmitter,
// one line per tick. Digits and status are snapshotted when a line starts so the line
// never tears. Optional macro DIC_TX_STATUS_EN inserts a status byte before CR/LF.
module dic_time_tx_fsm #(
    parameter logic [7:0] SEP_CHAR = 8'h3A,
    parameter logic [7:0] CR_CHAR  = 8'h0D,
    parameter logic [7:0] LF_CHAR  = 8'h0A,
    parameter logic [7:0] BAD_CHAR = 8'h3F
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tick,
    input  logic                      dicRun,
    input  logic                      alarm_ena,
    input  logic                      ld_time,
    input  logic                      ld_alarm,
    input  logic [3:0]                di_Mtens,
    input  logic [3:0]                di_Mones,
    input  logic [3:0]                di_Stens,
    input  logic [3:0]                di_Sones,
    dic_time_tx_fsm_if.master         tx,
    output logic                      busy,
    output logic                      line_done
);

    typedef enum logic [0:0] {IDLE, SEND} state_t;

`ifdef DIC_TX_STATUS_EN
    localparam logic [2:0] LAST_IDX = 3'd7;
`else
    localparam logic [2:0] LAST_IDX = 3'd6;
`endif

    state_t      state;
    logic [2:0]  idx;
    logic        pend;
    logic [15:0] snap_digits;
    logic [15:0] live_digits;
    logic        xfer;
    logic        last_xfer;

    assign live_digits = {di_Mtens, di_Mones, di_Stens, di_Sones};

    // ASCII for one BCD digit; codes 10-15 are not valid BCD.
    function automatic logic [7:0] digit_char(input logic [3:0] d);
        if (d <= 4'd9) begin
            return 8'h30 + {4'h0, d};
        end
        return BAD_CHAR;
    endfunction

`ifdef DIC_TX_STATUS_EN
    // Status bits packed as {ld_time, ld_alarm, dicRun, alarm_ena}.
    logic [3:0] snap_status;
    logic [3:0] live_status;

    assign live_status = {ld_time, ld_alarm, dicRun, alarm_ena};

    function automatic logic [7:0] status_char(input logic [3:0] st);
        logic [7:0] c;
        if (st[3]) begin
            c = 8'h4C;
        end else if (st[2]) begin
            c = 8'h41;
        end else if (st[1]) begin
            c = 8'h52;
        end else begin
            c = 8'h53;
        end
        // Lower case flags an enabled alarm.
        if (st[0]) begin
            c = c | 8'h20;
        end
        return c;
    endfunction

    function automatic logic [7:0] byte_of(input logic [2:0] i, input logic [15:0] dg,
                                           input logic [3:0] st);
        case (i)
            3'd0:    return digit_char(dg[15:12]);
            3'd1:    return digit_char(dg[11:8]);
            3'd2:    return SEP_CHAR;
            3'd3:    return digit_char(dg[7:4]);
            3'd4:    return digit_char(dg[3:0]);
            3'd5:    return status_char(st);
            3'd6:    return CR_CHAR;
            default: return LF_CHAR;
        endcase
    endfunction
`else
    // Status inputs only feed the optional status byte.
    logic unused_status;
    assign unused_status = ^{dicRun, alarm_ena, ld_time, ld_alarm};

    function automatic logic [7:0] byte_of(input logic [2:0] i, input logic [15:0] dg);
        case (i)
            3'd0:    return digit_char(dg[15:12]);
            3'd1:    return digit_char(dg[11:8]);
            3'd2:    return SEP_CHAR;
            3'd3:    return digit_char(dg[7:4]);
            3'd4:    return digit_char(dg[3:0]);
            3'd5:    return CR_CHAR;
            3'd6:    return LF_CHAR;
            default: return 8'h00;
        endcase
    endfunction
`endif

    // Handshake decode from registered state; tx_vld is high exactly while in SEND.
    assign tx.tx_vld = (state == SEND);
    assign busy      = (state == SEND);
    assign xfer      = (state == SEND) && tx.tx_rdy;
    assign last_xfer = xfer && (idx == LAST_IDX);
    assign line_done = last_xfer;

    // Line sequencer: snapshot on start, advance one byte per accepted transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= 3'd0;
            pend        <= 1'b0;
            snap_digits <= 16'h0000;
            tx.tx_data  <= 8'h00;
`ifdef DIC_TX_STATUS_EN
            snap_status <= 4'h0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (tick || pend) begin
                        state       <= SEND;
                        idx         <= 3'd0;
                        pend        <= 1'b0;
                        snap_digits <= live_digits;
`ifdef DIC_TX_STATUS_EN
                        snap_status <= live_status;
                        tx.tx_data  <= byte_of(3'd0, live_digits, live_status);
`else
                        tx.tx_data  <= byte_of(3'd0, live_digits);
`endif
                    end
                end
                SEND: begin
                    if (last_xfer) begin
                        if (tick || pend) begin
                            // Back-to-back line; this tick is consumed, not queued.
                            idx         <= 3'd0;
                            pend        <= 1'b0;
                            snap_digits <= live_digits;
`ifdef DIC_TX_STATUS_EN
                            snap_status <= live_status;
                            tx.tx_data  <= byte_of(3'd0, live_digits, live_status);
`else
                            tx.tx_data  <= byte_of(3'd0, live_digits);
`endif
                        end else begin
                            state      <= IDLE;
                            idx        <= 3'd0;
                            tx.tx_data <= 8'h00;
                        end
                    end else begin
                        if (tick) begin
                            pend <= 1'b1;
                        end
                        if (xfer) begin
                            idx        <= idx + 3'd1;
`ifdef DIC_TX_STATUS_EN
                            tx.tx_data <= byte_of(idx + 3'd1, snap_digits, snap_status);
`else
                            tx.tx_data <= byte_of(idx + 3'd1, snap_digits);
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dic_time_tx_fsm.sv
// Scoreboard bench for dic_time_tx_fsm: stimulus pushes expected bytes, a monitor pops
// and compares on every accepted transfer.
module tb_dic_time_tx_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tick = 1'b0;
    logic       dicRun = 1'b0;
    logic       alarm_ena = 1'b0;
    logic       ld_time = 1'b0;
    logic       ld_alarm = 1'b0;
    logic [3:0] mt = 4'd0;
    logic [3:0] mo = 4'd0;
    logic [3:0] st = 4'd0;
    logic [3:0] so = 4'd0;
    logic       busy;
    logic       line_done;

    dic_time_tx_fsm_if tx_if ();

    dic_time_tx_fsm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .dicRun    (dicRun),
        .alarm_ena (alarm_ena),
        .ld_time   (ld_time),
        .ld_alarm  (ld_alarm),
        .di_Mtens  (mt),
        .di_Mones  (mo),
        .di_Stens  (st),
        .di_Sones  (so),
        .tx        (tx_if),
        .busy      (busy),
        .line_done (line_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         xfer_cnt = 0;
    int         rdy_mode = 0;
    int         cyc = 0;
    bit         expect_b2b = 0;
    bit         holding = 0;
    logic [7:0] held = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] dchar(input logic [3:0] d);
        return (d < 4'd10) ? (8'h30 + {4'h0, d}) : 8'h3F;
    endfunction

    task automatic push_line(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                             input logic [3:0] d, input logic [7:0] status);
        exp_q.push_back('{data: dchar(a), last: 1'b0});
        exp_q.push_back('{data: dchar(b), last: 1'b0});
        exp_q.push_back('{data: 8'h3A, last: 1'b0});
        exp_q.push_back('{data: dchar(c), last: 1'b0});
        exp_q.push_back('{data: dchar(d), last: 1'b0});
`ifdef DIC_TX_STATUS_EN
        exp_q.push_back('{data: status, last: 1'b0});
`else
        if (status == 8'hFF) $display("note: status byte %0h ignored", status);
`endif
        exp_q.push_back('{data: 8'h0D, last: 1'b0});
        exp_q.push_back('{data: 8'h0A, last: 1'b1});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_pulse();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !busy) begin
                ok = 1;
                break;
            end
            step();
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL wait_idle: timeout, %0d bytes still expected", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_xfers(input int target, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (xfer_cnt >= target) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL wait_xfers: got %0d transfers want %0d", xfer_cnt, target);
        end
    endtask

    // Ready generator: always ready, or ready one cycle in three.
    initial begin
        tx_if.tx_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            tx_if.tx_rdy = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
        end
    end

    // Monitor: compares each accepted byte against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                holding    = 0;
                expect_b2b = 0;
            end else begin
                if (expect_b2b) begin
                    check("b2b_vld", 32'(tx_if.tx_vld), 32'd1);
                    expect_b2b = 0;
                end
                if (holding && tx_if.tx_vld) check("hold_data", 32'(tx_if.tx_data), 32'(held));
                if (tx_if.tx_vld && tx_if.tx_rdy) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_byte: got %0h want none", tx_if.tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", 32'(tx_if.tx_data), 32'(e.data));
                        check("line_done", 32'(line_done), 32'(e.last));
                        if (e.last && exp_q.size() > 0) expect_b2b = 1;
                    end
                    xfer_cnt++;
                end else if (tx_if.tx_vld) begin
                    check("line_done_stall", 32'(line_done), 32'd0);
                end
                holding = tx_if.tx_vld && !tx_if.tx_rdy;
                held    = tx_if.tx_data;
            end
        end
    end

    initial begin
        int base;
        // Reset state is visible before any clock edge.
        #1 rst_n = 1'b0;
        #2;
        check("rst_vld", 32'(tx_if.tx_vld), 32'd0);
        check("rst_data", 32'(tx_if.tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_line_done", 32'(line_done), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // 1: basic line, 1-cycle latency.
        mt = 4'd1; mo = 4'd2; st = 4'd3; so = 4'd4;
        check("idle_vld", 32'(tx_if.tx_vld), 32'd0);
        push_line(4'd1, 4'd2, 4'd3, 4'd4, 8'h53);
        tick_pulse();
        check("latency_vld", 32'(tx_if.tx_vld), 32'd1);
        check("latency_busy", 32'(busy), 32'd1);
        wait_idle(50);
        step();
        check("t1_idle_vld", 32'(tx_if.tx_vld), 32'd0);

        // 2: ready one cycle in three.
        rdy_mode = 1;
        push_line(4'd1, 4'd2, 4'd3, 4'd4, 8'h53);
        tick_pulse();
        wait_idle(100);
        rdy_mode = 0;
        step();

        // 3: live digit change mid-line does not tear.
        base = xfer_cnt;
        push_line(4'd1, 4'd2, 4'd3, 4'd4, 8'h53);
        tick_pulse();
        wait_xfers(base + 2, 20);
        so = 4'd5;
        wait_idle(50);
        push_line(4'd1, 4'd2, 4'd3, 4'd5, 8'h53);
        tick_pulse();
        wait_idle(50);
        so = 4'd4;

        // 4: three ticks during a line give exactly one back-to-back extra line.
        push_line(4'd1, 4'd2, 4'd3, 4'd4, 8'h53);
        push_line(4'd1, 4'd2, 4'd3, 4'd4, 8'h53);
        tick_pulse();
        step();
        tick_pulse();
        step();
        tick_pulse();
        tick_pulse();
        wait_idle(80);
        repeat (10) step();
        check("t4_idle_vld", 32'(tx_if.tx_vld), 32'd0);

        // 5: non-BCD digit.
        mo = 4'hC;
        push_line(4'd1, 4'hC, 4'd3, 4'd4, 8'h53);
        tick_pulse();
        wait_idle(50);
        mo = 4'd2;

        // 6: reset mid-line aborts the line and drops a pending request.
        base = xfer_cnt;
        push_line(4'd1, 4'd2, 4'd3, 4'd4, 8'h53);
        tick_pulse();
        tick_pulse();
        wait_xfers(base + 3, 20);
        #2 rst_n = 1'b0;
        #1;
        check("abort_vld", 32'(tx_if.tx_vld), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_data", 32'(tx_if.tx_data), 32'd0);
        exp_q.delete();
        step();
        #3 rst_n = 1'b1;
        repeat (12) step();
        check("post_abort_vld", 32'(tx_if.tx_vld), 32'd0);
        check("post_abort_busy", 32'(busy), 32'd0);

`ifdef DIC_TX_STATUS_EN
        // 7: status byte with alarm load and alarm enabled.
        ld_alarm = 1'b1;
        alarm_ena = 1'b1;
        push_line(4'd1, 4'd2, 4'd3, 4'd4, 8'h61);
        tick_pulse();
        wait_idle(50);
        ld_alarm = 1'b0;
        alarm_ena = 1'b0;
`endif

        repeat (3) step();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
